// File: rtl/arb_pkg.sv
// Shared types and constants for the N-input metadata arbiter.
package arb_pkg;

  typedef enum logic {
    ARB_RR   = 1'b0,
    ARB_PRIO = 1'b1
  } arb_mode_t;

  localparam int unsigned ARB_MAX_N    = 16;
  localparam int unsigned ARB_AF_SLACK = 32;
  localparam int unsigned META_WIDTH   = 64;

endpackage

// File: rtl/arb_n_fifo.sv
// Show-ahead single-clock FIFO with fill counter, overflow flag and registered almost-full.
module arb_n_fifo
  import arb_pkg::*;
#(
  parameter int unsigned DWIDTH     = META_WIDTH,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned FULL_LEVEL = DEPTH - ARB_AF_SLACK
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              wr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd,
  output logic [DWIDTH-1:0] rd_data_c,
  output logic              empty_c,
  output logic              drop_c,
  output logic              almost_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [FW-1:0]     fill;
  logic [FW-1:0]     fill_next;
  logic              full;
  logic              push;
  logic              pop;

  assign full      = (fill == FW'(DEPTH));
  assign empty_c   = (fill == '0);
  assign push      = wr && !full;
  assign pop       = rd && !empty_c;
  assign drop_c    = wr && full;
  assign rd_data_c = mem[rd_ptr];

  // Next fill level; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    fill_next = fill;
    if (push && !pop) begin
      fill_next = fill + FW'(1);
    end else if (pop && !push) begin
      fill_next = fill - FW'(1);
    end
  end

  // Pointers, fill and almost-full (from next fill, so it covers this cycle's write).
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fill        <= fill_next;
      almost_full <= (fill_next >= FW'(FULL_LEVEL));
    end
  end

  // Storage array; contents are don't-care once the pointers are reset.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/arb_n_af_service.sv
// N-input metadata arbiter: per-input FIFOs, RR or fixed-priority grant, one registered output.
// Optional per-channel grant counters on stats_grant when ARB_N_STATS_EN is defined.
module arb_n_af_service
  import arb_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned DWIDTH     = META_WIDTH,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned FULL_LEVEL = DEPTH - ARB_AF_SLACK,
  parameter arb_mode_t   MODE       = ARB_RR
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [N*DWIDTH-1:0]   in_data,
  input  logic [N-1:0]          in_valid,
  output logic [N-1:0]          in_almost_full,
  output logic [DWIDTH-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [$clog2(N)-1:0]  out_chan,
  output logic [N-1:0]          drop_err
`ifdef ARB_N_STATS_EN
  ,
  output logic [N*32-1:0]       stats_grant
`endif
);

  localparam int unsigned CW = $clog2(N);

  logic [N-1:0]      empty;
  logic [N-1:0]      drop;
  logic [N-1:0]      pop;
  logic [DWIDTH-1:0] head [N];
  logic [CW-1:0]     rr_ptr;
  logic [CW-1:0]     gnt_idx;
  logic              gnt_valid;
  logic              can_load;

  assign can_load = !out_valid || out_ready;

  // One buffering FIFO per input channel.
  for (genvar i = 0; i < int'(N); i++) begin : g_fifo
    arb_n_fifo #(
      .DWIDTH    (DWIDTH),
      .DEPTH     (DEPTH),
      .FULL_LEVEL(FULL_LEVEL)
    ) u_fifo (
      .Clk        (Clk),
      .Rst        (Rst),
      .wr         (in_valid[i]),
      .wr_data    (in_data[i*DWIDTH +: DWIDTH]),
      .rd         (pop[i]),
      .rd_data_c  (head[i]),
      .empty_c    (empty[i]),
      .drop_c     (drop[i]),
      .almost_full(in_almost_full[i])
    );
  end

  // Grant select: lowest index for PRIO, first non-empty after rr_ptr for RR.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (MODE == ARB_PRIO) begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (!empty[CW'(i)]) begin
          gnt_valid = 1'b1;
          gnt_idx   = CW'(i);
        end
      end
    end else begin
      for (int k = int'(N); k >= 1; k--) begin
        if (!empty[CW'((int'(rr_ptr) + k) % int'(N))]) begin
          gnt_valid = 1'b1;
          gnt_idx   = CW'((int'(rr_ptr) + k) % int'(N));
        end
      end
    end
  end

  // Pop the granted FIFO only when the output register takes its head.
  always_comb begin
    pop = '0;
    if (can_load && gnt_valid) pop[gnt_idx] = 1'b1;
  end

  // Output pass-through register and round-robin pointer.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= CW'(N - 1);
    end else if (can_load) begin
      out_valid <= gnt_valid;
      if (gnt_valid) begin
        out_data <= head[gnt_idx];
        out_chan <= gnt_idx;
        rr_ptr   <= gnt_idx;
      end
    end
  end

  // Sticky overflow flags.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      drop_err <= '0;
    end else begin
      drop_err <= drop_err | drop;
    end
  end

`ifdef ARB_N_STATS_EN
  // Per-channel grant counters, wrapping at 2^32.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stats_grant <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (pop[i]) stats_grant[i*32 +: 32] <= stats_grant[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule
